// File: rtl/black_level_clamp.sv
// Black-level clamp: tracks the blanking level on each line's back porch and
// outputs every captured sample re-centred on a filtered black estimate.
//
// state   | meaning
// --------+------------------------------------------------------------
// SEEK    | waiting for the first sample below the sync threshold
// SYNC    | counting consecutive sync-tip samples to qualify a pulse
// PORCH   | skipping breezeway and burst after the sync ends
// MEASURE | accumulating the back-porch window
// UPDATE  | single clock applying the IIR step to black_level
module black_level_clamp #(
  parameter int ADC_WIDTH     = 12,
  parameter int DEFAULT_BLACK = 2500,
  parameter int SYNC_THRESH   = 1800,
  parameter int SYNC_MIN      = 32,
  parameter int PORCH_DELAY   = 128,
  parameter int LOG2_N        = 4,
  parameter int ALPHA_SHIFT   = 2,
  parameter int LINE_TIMEOUT  = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_valid,
  input  logic [ADC_WIDTH-1:0]        adc_data,
  output logic signed [ADC_WIDTH:0]   pixel_out,
  output logic                        pixel_valid,
  output logic [ADC_WIDTH-1:0]        black_level,
  output logic                        clamp_locked,
  output logic                        update_pulse
);

  typedef enum logic [2:0] {SEEK, SYNC, PORCH, MEASURE, UPDATE} state_t;

  localparam int ACC_W = ADC_WIDTH + LOG2_N;
  localparam int LOW_W = $clog2(SYNC_MIN + 1);
  localparam int DLY_W = $clog2(PORCH_DELAY + 1);
  localparam int M_W   = LOG2_N + 1;
  localparam int TO_W  = $clog2(LINE_TIMEOUT + 1);

  localparam logic [LOW_W-1:0]     LOW_MAX  = LOW_W'(SYNC_MIN);
  localparam logic [DLY_W-1:0]     DLY_LAST = DLY_W'(PORCH_DELAY - 1);
  localparam logic [M_W-1:0]       M_LAST   = M_W'((1 << LOG2_N) - 1);
  localparam logic [TO_W-1:0]      TO_MAX   = TO_W'(LINE_TIMEOUT);
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(LINE_TIMEOUT - 1);
  localparam logic [ADC_WIDTH-1:0] THRESH_C = ADC_WIDTH'(SYNC_THRESH);
  localparam logic [ADC_WIDTH-1:0] DEF_C    = ADC_WIDTH'(DEFAULT_BLACK);

  state_t                  state;
  logic [LOW_W-1:0]        low_cnt;
  logic [DLY_W-1:0]        dly_cnt;
  logic [M_W-1:0]          m_cnt;
  logic [TO_W-1:0]         timeout_cnt;
  logic [ACC_W-1:0]        acc;

  logic                    is_low;
  logic [ADC_WIDTH-1:0]    avg;
  logic signed [ADC_WIDTH:0] diff;
  logic signed [ADC_WIDTH:0] step;
  logic [ADC_WIDTH-1:0]    bl_next;

  // Sync slicing and the IIR step; the result always lands between the old
  // estimate and the window average, so plain truncation back to ADC_WIDTH is safe.
  always_comb begin
    is_low  = adc_data < THRESH_C;
    avg     = ADC_WIDTH'(acc >> LOG2_N);
    diff    = $signed({1'b0, avg}) - $signed({1'b0, black_level});
    step    = diff >>> ALPHA_SHIFT;
    bl_next = ADC_WIDTH'($signed({1'b0, black_level}) + step);
  end

  // Pixel path: re-centre each valid sample on the estimate held this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= sample_valid;
      if (sample_valid)
        pixel_out <= $signed({1'b0, adc_data}) - $signed({1'b0, black_level});
    end
  end

  // Line FSM, window accumulation, IIR update and loss-of-sync timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= SEEK;
      low_cnt      <= '0;
      dly_cnt      <= '0;
      m_cnt        <= '0;
      timeout_cnt  <= '0;
      acc          <= '0;
      black_level  <= DEF_C;
      clamp_locked <= 1'b0;
      update_pulse <= 1'b0;
    end else begin
      update_pulse <= 1'b0;

      // Timeout is evaluated first so sync qualification and UPDATE can override it.
      if (state != UPDATE && sample_valid && timeout_cnt != TO_MAX) begin
        timeout_cnt <= timeout_cnt + TO_W'(1);
        if (timeout_cnt == TO_LAST) begin
          clamp_locked <= 1'b0;
          black_level  <= DEF_C;
        end
      end

      case (state)
        SEEK: begin
          if (sample_valid && is_low) begin
            low_cnt <= LOW_W'(1);
            state   <= SYNC;
          end
        end
        SYNC: begin
          if (sample_valid) begin
            if (is_low) begin
              if (low_cnt != LOW_MAX)
                low_cnt <= low_cnt + LOW_W'(1);
            end else if (low_cnt >= LOW_MAX) begin
              dly_cnt     <= '0;
              timeout_cnt <= '0;
              state       <= PORCH;
            end else begin
              state <= SEEK;
            end
          end
        end
        PORCH: begin
          if (sample_valid) begin
            if (is_low) begin
              low_cnt <= LOW_W'(1);
              state   <= SYNC;
            end else begin
              dly_cnt <= dly_cnt + DLY_W'(1);
              if (dly_cnt == DLY_LAST) begin
                acc   <= '0;
                m_cnt <= '0;
                state <= MEASURE;
              end
            end
          end
        end
        MEASURE: begin
          if (sample_valid) begin
            if (is_low) begin
              low_cnt <= LOW_W'(1);
              acc     <= '0;
              state   <= SYNC;
            end else begin
              acc   <= acc + ACC_W'(adc_data);
              m_cnt <= m_cnt + M_W'(1);
              if (m_cnt == M_LAST) begin
                update_pulse <= 1'b1;
                state        <= UPDATE;
              end
            end
          end
        end
        UPDATE: begin
          black_level  <= bl_next;
          clamp_locked <= 1'b1;
          timeout_cnt  <= '0;
          state        <= SEEK;
        end
        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_black_level_clamp.sv
// Directed bench for black_level_clamp: reset, single line, convergence,
// glitch rejection, measurement abort, reset mid-line and timeout.
module tb_black_level_clamp;

  logic               clk;
  logic               rst_n;
  logic               sample_valid;
  logic [11:0]        adc_data;
  logic signed [12:0] pixel_out;
  logic               pixel_valid;
  logic [11:0]        black_level;
  logic               clamp_locked;
  logic               update_pulse;

  int n_chk = 0;
  int n_bad = 0;
  int exp_bl = 2500;

  black_level_clamp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .adc_data     (adc_data),
    .pixel_out    (pixel_out),
    .pixel_valid  (pixel_valid),
    .black_level  (black_level),
    .clamp_locked (clamp_locked),
    .update_pulse (update_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic v, input logic [11:0] d);
    sample_valid = v;
    adc_data     = d;
    @(posedge clk);
    #1;
  endtask

  // Feeds n valid samples of level d, each followed by an idle clock.
  // cnt: update pulses seen; at: 1-based index of the sample whose edge raised one.
  task automatic feed(input logic [11:0] d, input int n, output int cnt, output int at);
    cnt = 0;
    at  = -1;
    for (int i = 0; i < n; i++) begin
      tick(1'b1, d);
      if (update_pulse) begin cnt++; at = i + 1; end
      tick(1'b0, d);
      if (update_pulse) cnt++;
    end
  endtask

  function automatic int iir(input int bl, input int avg);
    int d;
    d = avg - bl;
    return bl + (d >>> 2);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 12'd4095);
      n_chk++; if (pixel_out !== 13'sd0) begin n_bad++; $display("FAIL rst_pixel: got %0d want 0", pixel_out); end
      n_chk++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pvalid: got %b want 0", pixel_valid); end
      n_chk++; if (black_level !== 12'd2500) begin n_bad++; $display("FAIL rst_black: got %0d want 2500", black_level); end
      n_chk++; if (clamp_locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %b want 0", clamp_locked); end
    end
    rst_n = 1'b1;
    tick(1'b1, 12'd4095);
    n_chk++; if (pixel_out !== 13'sd1595) begin n_bad++; $display("FAIL first_pixel: got %0d want 1595", pixel_out); end
    n_chk++; if (pixel_valid !== 1'b1) begin n_bad++; $display("FAIL first_pvalid: got %b want 1", pixel_valid); end
    tick(1'b0, 12'd4095);
    n_chk++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL idle_pvalid: got %b want 0", pixel_valid); end
  endtask

  task automatic test_single_line;
    int c, a;
    feed(12'd1000, 200, c, a);
    n_chk++; if (c !== 0) begin n_bad++; $display("FAIL line_sync_upd: got %0d want 0", c); end
    feed(12'd2600, 144, c, a);
    n_chk++; if (c !== 0) begin n_bad++; $display("FAIL line_porch_upd: got %0d want 0", c); end
    n_chk++; if (clamp_locked !== 1'b0) begin n_bad++; $display("FAIL line_prelock: got %b want 0", clamp_locked); end
    tick(1'b1, 12'd2600);
    n_chk++; if (update_pulse !== 1'b1) begin n_bad++; $display("FAIL line_pulse: got %b want 1", update_pulse); end
    n_chk++; if (black_level !== 12'd2500) begin n_bad++; $display("FAIL line_old_black: got %0d want 2500", black_level); end
    n_chk++; if (pixel_out !== 13'sd100) begin n_bad++; $display("FAIL line_pre_pixel: got %0d want 100", pixel_out); end
    tick(1'b0, 12'd2600);
    n_chk++; if (update_pulse !== 1'b0) begin n_bad++; $display("FAIL line_pulse_end: got %b want 0", update_pulse); end
    n_chk++; if (black_level !== 12'd2525) begin n_bad++; $display("FAIL line_new_black: got %0d want 2525", black_level); end
    n_chk++; if (clamp_locked !== 1'b1) begin n_bad++; $display("FAIL line_lock: got %b want 1", clamp_locked); end
    tick(1'b1, 12'd2600);
    n_chk++; if (pixel_out !== 13'sd75) begin n_bad++; $display("FAIL line_post_pixel: got %0d want 75", pixel_out); end
    tick(1'b0, 12'd2600);
    feed(12'd2600, 154, c, a);
    n_chk++; if (c !== 0) begin n_bad++; $display("FAIL line_tail_upd: got %0d want 0", c); end
    exp_bl = 2525;
  endtask

  task automatic test_convergence;
    int c, a, prev;
    for (int l = 0; l < 20; l++) begin
      prev = int'(black_level);
      feed(12'd1000, 200, c, a);
      feed(12'd2600, 300, c, a);
      exp_bl = iir(exp_bl, 2600);
      n_chk++; if (c !== 1 || a !== 145) begin n_bad++; $display("FAIL conv_pulse line %0d: got cnt=%0d at=%0d want cnt=1 at=145", l, c, a); end
      n_chk++; if (int'(black_level) !== exp_bl) begin n_bad++; $display("FAIL conv_black line %0d: got %0d want %0d", l, black_level, exp_bl); end
      n_chk++; if (int'(black_level) < prev) begin n_bad++; $display("FAIL conv_monotonic line %0d: got %0d want >= %0d", l, black_level, prev); end
    end
    n_chk++; if (black_level < 12'd2597 || black_level > 12'd2600) begin n_bad++; $display("FAIL conv_final: got %0d want 2597..2600", black_level); end
  endtask

  task automatic test_glitch;
    int c, a;
    feed(12'd2800, 20, c, a);
    feed(12'd1000, 31, c, a);
    feed(12'd2800, 200, c, a);
    n_chk++; if (c !== 0) begin n_bad++; $display("FAIL glitch31_upd: got %0d want 0", c); end
    n_chk++; if (int'(black_level) !== exp_bl) begin n_bad++; $display("FAIL glitch31_black: got %0d want %0d", black_level, exp_bl); end
    feed(12'd1000, 32, c, a);
    feed(12'd2800, 200, c, a);
    exp_bl = iir(exp_bl, 2800);
    n_chk++; if (c !== 1 || a !== 145) begin n_bad++; $display("FAIL glitch32_pulse: got cnt=%0d at=%0d want cnt=1 at=145", c, a); end
    n_chk++; if (int'(black_level) !== exp_bl) begin n_bad++; $display("FAIL glitch32_black: got %0d want %0d", black_level, exp_bl); end
  endtask

  task automatic test_abort;
    int c, a;
    feed(12'd1000, 200, c, a);
    feed(12'd2600, 136, c, a);
    n_chk++; if (c !== 0) begin n_bad++; $display("FAIL abort_pre_upd: got %0d want 0", c); end
    // The aborting sample leaves low_cnt at 1, so 31 more lows complete a qualified sync.
    feed(12'd1000, 32, c, a);
    n_chk++; if (c !== 0) begin n_bad++; $display("FAIL abort_upd: got %0d want 0", c); end
    feed(12'd2600, 300, c, a);
    exp_bl = iir(exp_bl, 2600);
    n_chk++; if (c !== 1 || a !== 145) begin n_bad++; $display("FAIL abort_resync_pulse: got cnt=%0d at=%0d want cnt=1 at=145", c, a); end
    n_chk++; if (int'(black_level) !== exp_bl) begin n_bad++; $display("FAIL abort_resync_black: got %0d want %0d", black_level, exp_bl); end
    feed(12'd1000, 200, c, a);
    feed(12'd2600, 300, c, a);
    exp_bl = iir(exp_bl, 2600);
    n_chk++; if (c !== 1 || a !== 145) begin n_bad++; $display("FAIL abort_clean_pulse: got cnt=%0d at=%0d want cnt=1 at=145", c, a); end
    n_chk++; if (int'(black_level) !== exp_bl) begin n_bad++; $display("FAIL abort_clean_black: got %0d want %0d", black_level, exp_bl); end
  endtask

  task automatic test_reset_mid_measure;
    int c, a;
    feed(12'd1000, 200, c, a);
    feed(12'd2600, 135, c, a);
    rst_n = 1'b0;
    tick(1'b1, 12'd2600);
    n_chk++; if (pixel_out !== 13'sd0) begin n_bad++; $display("FAIL mrst_pixel: got %0d want 0", pixel_out); end
    n_chk++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_pvalid: got %b want 0", pixel_valid); end
    n_chk++; if (black_level !== 12'd2500) begin n_bad++; $display("FAIL mrst_black: got %0d want 2500", black_level); end
    n_chk++; if (clamp_locked !== 1'b0) begin n_bad++; $display("FAIL mrst_locked: got %b want 0", clamp_locked); end
    n_chk++; if (update_pulse !== 1'b0) begin n_bad++; $display("FAIL mrst_pulse: got %b want 0", update_pulse); end
    rst_n = 1'b1;
    exp_bl = 2500;
    feed(12'd2600, 20, c, a);
    n_chk++; if (c !== 0) begin n_bad++; $display("FAIL mrst_seek_upd: got %0d want 0", c); end
    feed(12'd1000, 200, c, a);
    feed(12'd2600, 300, c, a);
    exp_bl = iir(exp_bl, 2600);
    n_chk++; if (c !== 1 || a !== 145) begin n_bad++; $display("FAIL mrst_line_pulse: got cnt=%0d at=%0d want cnt=1 at=145", c, a); end
    n_chk++; if (int'(black_level) !== exp_bl) begin n_bad++; $display("FAIL mrst_line_black: got %0d want %0d", black_level, exp_bl); end
  endtask

  task automatic test_timeout;
    int c, a;
    feed(12'd1000, 200, c, a);
    feed(12'd2600, 145, c, a);
    exp_bl = iir(exp_bl, 2600);
    n_chk++; if (c !== 1) begin n_bad++; $display("FAIL to_line_pulse: got %0d want 1", c); end
    feed(12'd2600, 4095, c, a);
    n_chk++; if (clamp_locked !== 1'b1) begin n_bad++; $display("FAIL to_early_unlock: got %b want 1", clamp_locked); end
    n_chk++; if (int'(black_level) !== exp_bl) begin n_bad++; $display("FAIL to_early_black: got %0d want %0d", black_level, exp_bl); end
    tick(1'b1, 12'd2600);
    n_chk++; if (clamp_locked !== 1'b0) begin n_bad++; $display("FAIL to_unlock: got %b want 0", clamp_locked); end
    n_chk++; if (black_level !== 12'd2500) begin n_bad++; $display("FAIL to_black: got %0d want 2500", black_level); end
    tick(1'b1, 12'd2600);
    n_chk++; if (pixel_out !== 13'sd100) begin n_bad++; $display("FAIL to_pixel: got %0d want 100", pixel_out); end
  endtask

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    adc_data     = '0;
    test_reset;
    test_single_line;
    test_convergence;
    test_glitch;
    test_abort;
    test_reset_mid_measure;
    test_timeout;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
